// File: rtl/mcs8_timing.sv
// MCS8 machine-state sequencer driven by the CLK1/CLK2 phase-pulse enables.
// Produces SYNC, the 8008-style state code, INTA and a sticky phase-sequence error.
module mcs8_timing (
    input  logic       CLK_I,
    input  logic       nRST_I,
    input  logic       CLK1_I,
    input  logic       CLK2_I,
    input  logic       READY_I,
    input  logic       INT_I,
    input  logic       HALT_I,
    input  logic       LAST_I,
    output logic       SYNC_O,
    output logic [2:0] STATE_O,
    output logic       INTA_O,
    output logic       PHASE_ERR_O
);

    typedef enum logic [2:0] {
        T1      = 3'b010,
        T1I     = 3'b110,
        T2      = 3'b100,
        TWAIT   = 3'b000,
        T3      = 3'b001,
        STOPPED = 3'b011,
        T4      = 3'b111,
        T5      = 3'b101
    } state_t;

    typedef enum logic [1:0] {
        LAST_NONE = 2'd0,
        LAST_CLK1 = 2'd1,
        LAST_CLK2 = 2'd2
    } pulse_t;

    state_t state;
    state_t next_state;
    state_t cycle_start;
    pulse_t last_pulse;
    logic   started;
    logic   half;
    logic   int_latch;
    logic   sync;
    logic   inta;
    logic   phase_err;
    logic   boundary;
    logic   seq_bad;

    // A new machine cycle begins in T1I whenever an interrupt is pending.
    assign cycle_start = int_latch ? T1I : T1;
    assign boundary    = CLK1_I && started && half;

    always_comb begin
        next_state = state;
        case (state)
            T1, T1I: next_state = T2;
            T2:      next_state = READY_I ? T3 : TWAIT;
            TWAIT:   next_state = READY_I ? T3 : TWAIT;
            T3: begin
                if (HALT_I)
                    next_state = STOPPED;
                else if (LAST_I)
                    next_state = cycle_start;
                else
                    next_state = T4;
            end
            T4:      next_state = T5;
            T5:      next_state = cycle_start;
            STOPPED: next_state = int_latch ? T1I : STOPPED;
            default: next_state = T1;
        endcase
    end

    assign seq_bad = (CLK1_I && CLK2_I)
                  || (CLK1_I && last_pulse == LAST_CLK1)
                  || (CLK2_I && last_pulse != LAST_CLK1);

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state      <= T1;
            started    <= 1'b0;
            half       <= 1'b0;
            sync       <= 1'b0;
            inta       <= 1'b0;
            int_latch  <= 1'b0;
            last_pulse <= LAST_NONE;
            phase_err  <= 1'b0;
        end else begin
            if (CLK1_I) begin
                if (!started) begin
                    // First pulse after reset opens T1 half 0 with no transition.
                    started <= 1'b1;
                    half    <= 1'b0;
                    sync    <= 1'b1;
                end else if (half) begin
                    half  <= 1'b0;
                    sync  <= 1'b1;
                    state <= next_state;
                    inta  <= (next_state == T1I);
                end else begin
                    half <= 1'b1;
                    sync <= 1'b0;
                end
            end

            // Clearing on T1I entry beats a coincident new request.
            if (boundary && next_state == T1I)
                int_latch <= 1'b0;
            else if (CLK1_I && INT_I)
                int_latch <= 1'b1;

            if (CLK1_I)
                last_pulse <= LAST_CLK1;
            else if (CLK2_I)
                last_pulse <= LAST_CLK2;

            if (seq_bad)
                phase_err <= 1'b1;
        end
    end

    assign SYNC_O      = sync;
    assign STATE_O     = state;
    assign INTA_O      = inta;
    assign PHASE_ERR_O = phase_err;

endmodule

// File: tb/tb_mcs8_timing.sv
// Directed bench for mcs8_timing: standard two-phase pattern, WAIT, HALT/INT,
// phase-error injection and asynchronous reset, all against hand-derived codes.
module tb_mcs8_timing;

    localparam logic [2:0] S_T1  = 3'b010;
    localparam logic [2:0] S_T1I = 3'b110;
    localparam logic [2:0] S_T2  = 3'b100;
    localparam logic [2:0] S_WT  = 3'b000;
    localparam logic [2:0] S_T3  = 3'b001;
    localparam logic [2:0] S_STP = 3'b011;
    localparam logic [2:0] S_T4  = 3'b111;
    localparam logic [2:0] S_T5  = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk1 = 1'b0;
    logic       clk2 = 1'b0;
    logic       ready = 1'b1;
    logic       intr = 1'b0;
    logic       halt = 1'b0;
    logic       last = 1'b1;
    logic       sync;
    logic [2:0] state;
    logic       inta;
    logic       perr;

    int total = 0;
    int bad   = 0;

    mcs8_timing dut (
        .CLK_I      (clk),
        .nRST_I     (rst_n),
        .CLK1_I     (clk1),
        .CLK2_I     (clk2),
        .READY_I    (ready),
        .INT_I      (intr),
        .HALT_I     (halt),
        .LAST_I     (last),
        .SYNC_O     (sync),
        .STATE_O    (state),
        .INTA_O     (inta),
        .PHASE_ERR_O(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One CLK_I cycle with the given phase pulses; returns #1 after the edge.
    task automatic cyc(input logic p1, input logic p2);
        @(negedge clk);
        clk1 = p1;
        clk2 = p2;
        @(posedge clk);
        #1;
        clk1 = 1'b0;
        clk2 = 1'b0;
    endtask

    // One full state with the standard generator; optional INT pulse on the mid CLK1.
    task automatic do_state(input logic [2:0] exp, input logic int_mid);
        cyc(1'b1, 1'b0);
        chk("state_h0", state, exp);
        chk("sync_h0", sync, 1);
        chk("inta", inta, (exp == S_T1I) ? 1 : 0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("sync_h0_hold", sync, 1);
        intr = int_mid;
        cyc(1'b1, 1'b0);
        intr = 1'b0;
        chk("state_h1", state, exp);
        chk("sync_h1", sync, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("sync_h1_hold", sync, 0);
        chk("perr_clean", perr, 0);
    endtask

    initial begin
        #12;
        chk("rst_sync", sync, 0);
        chk("rst_state", state, S_T1);
        chk("rst_inta", inta, 0);
        chk("rst_perr", perr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short machine cycle: T1, T2, T3, T1
        do_state(S_T1, 1'b0);
        do_state(S_T2, 1'b0);
        do_state(S_T3, 1'b0);
        do_state(S_T1, 1'b0);

        // Long machine cycle: T2, T3, T4, T5, T1
        last = 1'b0;
        do_state(S_T2, 1'b0);
        do_state(S_T3, 1'b0);
        do_state(S_T4, 1'b0);
        do_state(S_T5, 1'b0);
        last = 1'b1;
        do_state(S_T1, 1'b0);

        // Three WAIT states then T3
        ready = 1'b0;
        do_state(S_T2, 1'b0);
        do_state(S_WT, 1'b0);
        do_state(S_WT, 1'b0);
        do_state(S_WT, 1'b0);
        ready = 1'b1;
        do_state(S_T3, 1'b0);
        do_state(S_T1, 1'b0);

        // HALT into STOPPED, INT wakes into T1I, latch then clears
        halt = 1'b1;
        do_state(S_T2, 1'b0);
        do_state(S_T3, 1'b0);
        do_state(S_STP, 1'b0);
        do_state(S_STP, 1'b0);
        do_state(S_STP, 1'b1);
        halt = 1'b0;
        do_state(S_T1I, 1'b0);
        do_state(S_T2, 1'b0);
        do_state(S_T3, 1'b0);
        do_state(S_T1, 1'b0);

        // Asynchronous reset during WAIT
        ready = 1'b0;
        do_state(S_T2, 1'b0);
        cyc(1'b1, 1'b0);
        chk("wait_entry", state, S_WT);
        cyc(1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sync", sync, 0);
        chk("async_rst_state", state, S_T1);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        do_state(S_T1, 1'b0);
        do_state(S_T2, 1'b0);

        // Double CLK1 without CLK2
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0);
        chk("perr_first_clk1", perr, 0);
        cyc(1'b1, 1'b0);
        chk("perr_double_clk1", perr, 1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("perr_sticky", perr, 1);

        // CLK1 and CLK2 together
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("perr_cleared", perr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        chk("perr_idle", perr, 0);
        cyc(1'b1, 1'b1);
        chk("perr_overlap", perr, 1);
        cyc(1'b0, 1'b0);
        chk("perr_overlap_hold", perr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
